bram_burst_responder: RTL

- Responder end of the full-page burst handshake (rw_en/rw/f_addr/ready, f2s_data_valid, s2f_data_valid) driven by the frame-buffer arbiter.
- Backs the protocol with on-chip block RAM instead of external SDRAM.
- Drop-in substitute for the SDRAM controller for reduced-size frame tests and fast simulation of the arbiter, camera FIFO and VGA FIFO paths.
- Same port semantics: one accepted request moves exactly BURST_LEN words.

---
 rtl/bram_burst_responder.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/bram_burst_responder.sv
// bram_burst_responder
//   Block-RAM backed responder for the full-page burst handshake used by the
//   frame-buffer arbiter. Substitutes for the SDRAM controller in reduced-size
//   frame tests and fast simulation. One accepted request moves exactly
//   BURST_LEN words to or from page f_addr[PAGE_W-1:0].
//
//   Optional build macro: BRAM_BURST_RESPONDER_PROTO_CHECK_EN
//     When defined, proto_err flags (sticky until reset) an rw_en seen during
//     INIT or RECOVER, and nonzero upper f_addr bits on an accepted request.
//     When undefined, proto_err is tied low and the check logic is absent.
//
//   Handshake: a request is accepted on a rising edge where ready=1 and
//   rw_en=1; rw_en with ready=0 is dropped (never queued). The write strobe
//   f2s_data_valid tells the initiator to pop its FIFO; f2s_data must be stable
//   before the edge that ends each strobe cycle. s2f_data is valid exactly
//   while s2f_data_valid=1. All outputs come straight from flops.
module bram_burst_responder #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 15,
   parameter int PAGE_W       = 4,
   parameter int BURST_LEN    = 512,
   parameter int INIT_CYCLES  = 8,
   parameter int READ_LATENCY = 3,
   parameter int RECOVERY     = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rw,
   input  logic              rw_en,
   input  logic [ADDR_W-1:0] f_addr,
   input  logic [DATA_W-1:0] f2s_data,
   output logic [DATA_W-1:0] s2f_data,
   output logic              s2f_data_valid,
   output logic              f2s_data_valid,
   output logic              ready,
   output logic              proto_err
);

   localparam int IDX_W  = $clog2(BURST_LEN);
   localparam int MEM_AW = PAGE_W + IDX_W;
   localparam int CNT_W  = 16;

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(READ_LATENCY - 2);
   localparam logic [CNT_W-1:0] REC_LAST  = CNT_W'(RECOVERY - 1);

   typedef enum logic [2:0] {
      S_INIT,
      S_IDLE,
      S_WR_BURST,
      S_RD_LAT,
      S_RD_BURST,
      S_RECOVER
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
   logic [PAGE_W-1:0]   page_q, page_d;
   logic                ready_q, ready_d;
   logic                f2s_v_q, f2s_v_d;
   logic                s2f_v_q, s2f_v_d;
   logic                rd_en, wr_en;
   logic [MEM_AW-1:0]   rd_addr, wr_addr;
   logic [DATA_W-1:0]   rd_data_q;

   logic [DATA_W-1:0]   mem [0:(2**MEM_AW)-1];

   assign idx_nxt = idx_q + IDX_W'(1);
   assign wr_addr = {page_q, idx_q};

   // Next-state, counter and registered-output decode for the burst FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      page_d  = page_q;
      ready_d = ready_q;
      f2s_v_d = f2s_v_q;
      s2f_v_d = s2f_v_q;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      rd_addr = {page_q, idx_q};
      case (state_q)
         S_INIT: begin
            if (cnt_q == INIT_LAST) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_IDLE: begin
            if (rw_en) begin
               page_d  = f_addr[PAGE_W-1:0];
               ready_d = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               if (rw) begin
                  state_d = S_RD_LAT;
               end else begin
                  state_d = S_WR_BURST;
                  f2s_v_d = 1'b1;
               end
            end
         end
         S_WR_BURST: begin
            // Each strobe cycle ends with the word landing at the current index.
            wr_en = 1'b1;
            if (idx_q == IDX_LAST) begin
               f2s_v_d = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_RECOVER;
            end else begin
               idx_d = idx_nxt;
            end
         end
         S_RD_LAT: begin
            // Word 0 is fetched on the edge that also raises the read strobe.
            if (cnt_q == LAT_LAST) begin
               rd_en   = 1'b1;
               rd_addr = {page_q, idx_q};
               s2f_v_d = 1'b1;
               cnt_d   = '0;
               state_d = S_RD_BURST;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RD_BURST: begin
            // idx_q is the word being presented; prefetch the following one.
            if (idx_q == IDX_LAST) begin
               s2f_v_d = 1'b0;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_RECOVER;
            end else begin
               rd_en   = 1'b1;
               rd_addr = {page_q, idx_nxt};
               idx_d   = idx_nxt;
            end
         end
         S_RECOVER: begin
            if (cnt_q == REC_LAST) begin
               state_d = S_IDLE;
               ready_d = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = '0;
            ready_d = 1'b0;
            f2s_v_d = 1'b0;
            s2f_v_d = 1'b0;
         end
      endcase
   end

   // FSM state, counters and output flags; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         idx_q   <= '0;
         page_q  <= '0;
         ready_q <= 1'b0;
         f2s_v_q <= 1'b0;
         s2f_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         page_q  <= page_d;
         ready_q <= ready_d;
         f2s_v_q <= f2s_v_d;
         s2f_v_q <= s2f_v_d;
      end
   end

   // Block-RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= f2s_data;
      end
   end

   // Block-RAM read port registered straight onto s2f_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (rd_en) begin
         rd_data_q <= mem[rd_addr];
      end
   end

   assign s2f_data       = rd_data_q;
   assign s2f_data_valid = s2f_v_q;
   assign f2s_data_valid = f2s_v_q;
   assign ready          = ready_q;

`ifdef BRAM_BURST_RESPONDER_PROTO_CHECK_EN
   logic err_q;
   logic err_set;

   // Flag an impatient initiator or an out-of-range page on acceptance.
   always_comb begin
      err_set = 1'b0;
      if (rw_en && (state_q == S_INIT || state_q == S_RECOVER)) begin
         err_set = 1'b1;
      end
      if (rw_en && state_q == S_IDLE && (f_addr[ADDR_W-1:PAGE_W] != '0)) begin
         err_set = 1'b1;
      end
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (err_set) begin
         err_q <= 1'b1;
      end
   end

   assign proto_err = err_q;
`else
   logic unused_upper_addr;
   assign unused_upper_addr = ^f_addr[ADDR_W-1:PAGE_W];
   assign proto_err = 1'b0;
`endif

endmodule
